arb_m2s1: RTL and testbench



---
 rtl/sigma_tile_pkg.sv | 20 ++
 rtl/arb_m2s1_if.sv | 41 ++++
 rtl/arb_rd_tag_fifo.sv | 72 +++++++
 rtl/arb_m2s1.sv | 109 ++++++++++
 tb/tb_arb_m2s1.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/sigma_tile_pkg.sv
// Shared types for the sigma tile: master ids and the MemSplit32 request payload.
package sigma_tile_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;

    typedef logic master_id_t;

    localparam master_id_t MID_M0 = 1'b0;
    localparam master_id_t MID_M1 = 1'b1;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] wdata;
    } ms_req_t;

endpackage

// File: rtl/arb_m2s1_if.sv
// MemSplit32 two-master / one-slave bundle; slave modport is the arbiter's view.
interface arb_m2s1_if;
    import sigma_tile_pkg::*;

    logic              m0_req,   m1_req;
    logic              m0_we,    m1_we;
    logic [ADDR_W-1:0] m0_addr,  m1_addr;
    logic [BE_W-1:0]   m0_be,    m1_be;
    logic [DATA_W-1:0] m0_wdata, m1_wdata;
    logic              m0_ack,   m1_ack;
    logic              m0_resp,  m1_resp;
    logic [DATA_W-1:0] m0_rdata, m1_rdata;

    logic              s_req;
    logic              s_we;
    logic [ADDR_W-1:0] s_addr;
    logic [BE_W-1:0]   s_be;
    logic [DATA_W-1:0] s_wdata;
    logic              s_ack;
    logic              s_resp;
    logic [DATA_W-1:0] s_rdata;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_be, m0_wdata,
        input  m1_req, m1_we, m1_addr, m1_be, m1_wdata,
        output m0_ack, m0_resp, m0_rdata,
        output m1_ack, m1_resp, m1_rdata,
        output s_req, s_we, s_addr, s_be, s_wdata,
        input  s_ack, s_resp, s_rdata
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_be, m0_wdata,
        output m1_req, m1_we, m1_addr, m1_be, m1_wdata,
        input  m0_ack, m0_resp, m0_rdata,
        input  m1_ack, m1_resp, m1_rdata,
        input  s_req, s_we, s_addr, s_be, s_wdata,
        output s_ack, s_resp, s_rdata
    );

endinterface

// File: rtl/arb_rd_tag_fifo.sv
// In-order FIFO of master ids, one entry per outstanding read.
module arb_rd_tag_fifo
    import sigma_tile_pkg::*;
#(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned DEPTH_LOG = $clog2(DEPTH)
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 push_i,
    input  master_id_t           push_id_i,
    input  logic                 pop_i,
    output master_id_t           head_o,
    output logic [DEPTH_LOG:0]   cnt_o,
    output logic                 full_o,
    output logic                 empty_o
);

    localparam int unsigned CNT_W = DEPTH_LOG + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    master_id_t           mem_q [DEPTH];
    master_id_t           mem_d [DEPTH];
    logic [DEPTH_LOG-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 do_push, do_pop;

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        do_push  = push_i && (cnt_q != FULL_CNT);
        do_pop   = pop_i  && (cnt_q != '0);
        if (do_push) begin
            mem_d[wr_ptr_q] = push_id_i;
            wr_ptr_d        = wr_ptr_q + DEPTH_LOG'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + DEPTH_LOG'(1);
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= MID_M0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign cnt_o   = cnt_q;
    assign full_o  = (cnt_q == FULL_CNT);
    assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/arb_m2s1.sv
// Two-master to one-slave MemSplit32 arbiter: round-robin with grant lock, in-order read steering.
module arb_m2s1
    import sigma_tile_pkg::*;
#(
    parameter int unsigned RD_DEPTH     = 4,
    parameter int unsigned RD_DEPTH_LOG = $clog2(RD_DEPTH)
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    arb_m2s1_if.slave  bus,
    output logic       err_o
);

    logic                  rr_last_q, rr_last_d;
    logic                  lock_valid_q, lock_valid_d;
    master_id_t            lock_owner_q, lock_owner_d;
    logic                  err_q, err_d;

    ms_req_t               m0_f, m1_f, win_f;
    master_id_t            winner;
    logic                  win_req, blocked, issue, xfer, rsp_ok;

    master_id_t            head_id;
    logic [RD_DEPTH_LOG:0] rd_cnt;
    logic                  fifo_full, fifo_empty;

    // Winner is picked from registered state plus live requests; a blocked winner holds the bus idle.
    always_comb begin
        m0_f = '{we: bus.m0_we, addr: bus.m0_addr, be: bus.m0_be, wdata: bus.m0_wdata};
        m1_f = '{we: bus.m1_we, addr: bus.m1_addr, be: bus.m1_be, wdata: bus.m1_wdata};
        if (lock_valid_q) begin
            winner = lock_owner_q;
        end else if (bus.m0_req && bus.m1_req) begin
            winner = ~rr_last_q;
        end else if (bus.m1_req) begin
            winner = MID_M1;
        end else begin
            winner = MID_M0;
        end
        win_req = (winner == MID_M1) ? bus.m1_req : bus.m0_req;
        win_f   = (winner == MID_M1) ? m1_f : m0_f;
        blocked = !win_f.we && fifo_full;
        issue   = win_req && !blocked;
        xfer    = issue && bus.s_ack;
    end

    always_comb begin
        bus.s_req = issue;
        {bus.s_we, bus.s_addr, bus.s_be, bus.s_wdata} = issue ? win_f : '0;
        bus.m0_ack = xfer && (winner == MID_M0);
        bus.m1_ack = xfer && (winner == MID_M1);
    end

    // Responses go to the oldest outstanding reader; anything else is dropped.
    always_comb begin
        rsp_ok       = bus.s_resp && (rd_cnt != '0);
        bus.m0_resp  = rsp_ok && (head_id == MID_M0);
        bus.m1_resp  = rsp_ok && (head_id == MID_M1);
        bus.m0_rdata = bus.m0_resp ? bus.s_rdata : '0;
        bus.m1_rdata = bus.m1_resp ? bus.s_rdata : '0;
    end

    always_comb begin
        rr_last_d    = rr_last_q;
        lock_valid_d = lock_valid_q;
        lock_owner_d = lock_owner_q;
        err_d        = err_q || (bus.s_resp && fifo_empty);
        if (issue && !bus.s_ack) begin
            lock_valid_d = 1'b1;
            lock_owner_d = winner;
        end
        if (xfer) begin
            lock_valid_d = 1'b0;
            rr_last_d    = winner;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rr_last_q    <= MID_M1;
            lock_valid_q <= 1'b0;
            lock_owner_q <= MID_M0;
            err_q        <= 1'b0;
        end else begin
            rr_last_q    <= rr_last_d;
            lock_valid_q <= lock_valid_d;
            lock_owner_q <= lock_owner_d;
            err_q        <= err_d;
        end
    end

    assign err_o = err_q;

    arb_rd_tag_fifo #(
        .DEPTH     (RD_DEPTH),
        .DEPTH_LOG (RD_DEPTH_LOG)
    ) u_rd_tag_fifo (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .push_i    (xfer && !win_f.we),
        .push_id_i (winner),
        .pop_i     (rsp_ok),
        .head_o    (head_id),
        .cnt_o     (rd_cnt),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

endmodule

// File: tb/tb_arb_m2s1.sv
// Directed bench for arb_m2s1 with a read-response scoreboard.
module tb_arb_m2s1;
    import sigma_tile_pkg::*;

    localparam logic [31:0] WMASK = 32'h5A5A_5A5A;

    typedef struct {
        master_id_t  mid;
        logic [31:0] data;
    } exp_rsp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        err;
    exp_rsp_t    sb[$];
    int unsigned n_cmp = 0;
    int unsigned n_mis = 0;

    always #5 clk = ~clk;

    arb_m2s1_if bus ();

    arb_m2s1 #(.RD_DEPTH(4)) u_dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus.slave),
        .err_o   (err)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        bus.s_resp  = 1'b0;
        bus.s_rdata = '0;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive_m(input master_id_t id, input logic req, input logic we,
                           input logic [31:0] addr);
        if (id == MID_M0) begin
            bus.m0_req = req; bus.m0_we = we; bus.m0_addr = addr;
            bus.m0_be = 4'hC; bus.m0_wdata = addr ^ WMASK;
        end else begin
            bus.m1_req = req; bus.m1_we = we; bus.m1_addr = addr;
            bus.m1_be = 4'h3; bus.m1_wdata = addr ^ WMASK;
        end
    endtask

    // Assumes s_ack=1; a read grant queues the data the slave will later return.
    task automatic expect_grant(input string tag, input master_id_t id, input logic [31:0] addr,
                                input logic we, input logic [31:0] rdata);
        check_eq({tag, "_sreq"},  32'(bus.s_req), 32'd1);
        check_eq({tag, "_swe"},   32'(bus.s_we), 32'(we));
        check_eq({tag, "_saddr"}, bus.s_addr, addr);
        check_eq({tag, "_swd"},   bus.s_wdata, addr ^ WMASK);
        check_eq({tag, "_sbe"},   32'(bus.s_be), (id == MID_M0) ? 32'hC : 32'h3);
        check_eq({tag, "_ack0"},  32'(bus.m0_ack), 32'(id == MID_M0));
        check_eq({tag, "_ack1"},  32'(bus.m1_ack), 32'(id == MID_M1));
        if (!we) sb.push_back('{mid: id, data: rdata});
    endtask

    task automatic expect_stall(input string tag);
        check_eq({tag, "_sreq"},  32'(bus.s_req), 32'd0);
        check_eq({tag, "_sflds"}, bus.s_addr | bus.s_wdata | 32'(bus.s_be) | 32'(bus.s_we), 32'd0);
        check_eq({tag, "_acks"},  32'({bus.m0_ack, bus.m1_ack}), 32'd0);
    endtask

    task automatic resp_drive(input string tag);
        exp_rsp_t e;
        check_eq({tag, "_sb"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            bus.s_resp  = 1'b1;
            bus.s_rdata = e.data;
            settle();
            check_eq({tag, "_r0"},  32'(bus.m0_resp), 32'(e.mid == MID_M0));
            check_eq({tag, "_r1"},  32'(bus.m1_resp), 32'(e.mid == MID_M1));
            check_eq({tag, "_d0"},  bus.m0_rdata, (e.mid == MID_M0) ? e.data : 32'd0);
            check_eq({tag, "_d1"},  bus.m1_rdata, (e.mid == MID_M1) ? e.data : 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        drive_m(MID_M0, 1'b0, 1'b0, 32'h0);
        drive_m(MID_M1, 1'b0, 1'b0, 32'h0);
        bus.s_ack = 1'b0; bus.s_resp = 1'b1; bus.s_rdata = 32'h1111;
        #12;
        check_eq("rst_err",  32'(err), 32'd0);
        check_eq("rst_sreq", 32'(bus.s_req), 32'd0);
        check_eq("rst_resp", 32'({bus.m0_resp, bus.m1_resp}), 32'd0);
        tick();
        rst_n = 1'b1;

        // Contention: alternate grants starting with m0.
        drive_m(MID_M0, 1'b1, 1'b0, 32'h100);
        drive_m(MID_M1, 1'b1, 1'b0, 32'h200);
        bus.s_ack = 1'b1;
        settle(); expect_grant("c0", MID_M0, 32'h100, 1'b0, 32'hAAAA); tick();
        settle(); expect_grant("c1", MID_M1, 32'h200, 1'b0, 32'hBBBB); tick();
        settle(); expect_grant("c2", MID_M0, 32'h100, 1'b0, 32'hAAA1); tick();
        settle(); expect_grant("c3", MID_M1, 32'h200, 1'b0, 32'hBBB1); tick();
        bus.m0_req = 1'b0; bus.m1_req = 1'b0; bus.s_ack = 1'b0;
        repeat (4) begin resp_drive("c_rsp"); tick(); end

        // Grant lock: m1 write held while m0 starts requesting.
        drive_m(MID_M1, 1'b1, 1'b1, 32'h8000_0004);
        settle();
        check_eq("lk0_saddr", bus.s_addr, 32'h8000_0004);
        check_eq("lk0_ack1",  32'(bus.m1_ack), 32'd0);
        tick();
        drive_m(MID_M0, 1'b1, 1'b0, 32'h300);
        settle();
        check_eq("lk1_saddr", bus.s_addr, 32'h8000_0004);
        check_eq("lk1_acks",  32'({bus.m0_ack, bus.m1_ack}), 32'd0);
        tick(); settle();
        check_eq("lk2_saddr", bus.s_addr, 32'h8000_0004);
        tick();
        bus.s_ack = 1'b1;
        settle(); expect_grant("lk3", MID_M1, 32'h8000_0004, 1'b1, 32'h0); tick();
        bus.m1_req = 1'b0;
        settle(); expect_grant("lk4", MID_M0, 32'h300, 1'b0, 32'hC0DE); tick();
        bus.m0_req = 1'b0; bus.s_ack = 1'b0;
        resp_drive("lk_rsp"); tick();

        // FIFO full: 3 m0 reads + 1 m1 read, then m0 read blocked while m1 write waits.
        bus.s_ack = 1'b1;
        drive_m(MID_M0, 1'b1, 1'b0, 32'h400);
        for (int i = 0; i < 3; i++) begin
            settle(); expect_grant("ff_m0", MID_M0, 32'h400, 1'b0, 32'hD0 + 32'(i)); tick();
        end
        bus.m0_req = 1'b0;
        drive_m(MID_M1, 1'b1, 1'b0, 32'h410);
        settle(); expect_grant("ff_m1", MID_M1, 32'h410, 1'b0, 32'hD3); tick();
        drive_m(MID_M0, 1'b1, 1'b0, 32'h404);
        drive_m(MID_M1, 1'b1, 1'b1, 32'h500);
        settle(); expect_stall("ff_st0"); tick();
        settle(); expect_stall("ff_st1"); tick();
        resp_drive("ff_pop"); expect_stall("ff_st2"); tick();
        settle(); expect_grant("ff_go", MID_M0, 32'h404, 1'b0, 32'hD4); tick();
        bus.m0_req = 1'b0;
        settle(); expect_grant("ff_wr", MID_M1, 32'h500, 1'b1, 32'h0); tick();
        bus.m1_req = 1'b0; bus.s_ack = 1'b0;
        resp_drive("ff_pop2"); tick();

        // Push and pop together at cnt=3, then drain across the pointer wrap.
        bus.s_ack = 1'b1;
        drive_m(MID_M1, 1'b1, 1'b0, 32'h600);
        resp_drive("wr_pp"); expect_grant("wr_pp", MID_M1, 32'h600, 1'b0, 32'hE0); tick();
        bus.m1_req = 1'b0;
        drive_m(MID_M0, 1'b1, 1'b0, 32'h604);
        settle(); expect_grant("wr_m0", MID_M0, 32'h604, 1'b0, 32'hE1); tick();
        settle(); expect_stall("wr_full"); tick();
        bus.m0_req = 1'b0; bus.s_ack = 1'b0;
        repeat (4) begin resp_drive("wr_drain"); tick(); end

        // Spurious response with an empty FIFO.
        bus.s_resp = 1'b1; bus.s_rdata = 32'hDEAD;
        settle();
        check_eq("sp_resp", 32'({bus.m0_resp, bus.m1_resp}), 32'd0);
        check_eq("sp_rdat", bus.m0_rdata | bus.m1_rdata, 32'd0);
        check_eq("sp_pre",  32'(err), 32'd0);
        tick(); settle();
        check_eq("sp_err",  32'(err), 32'd1);
        repeat (3) tick();
        settle();
        check_eq("sp_stky", 32'(err), 32'd1);

        // Async reset mid-lock with two reads outstanding.
        bus.s_ack = 1'b1;
        drive_m(MID_M0, 1'b1, 1'b0, 32'h900);
        settle(); expect_grant("ar_m0", MID_M0, 32'h900, 1'b0, 32'hF0); tick();
        bus.m0_req = 1'b0;
        drive_m(MID_M1, 1'b1, 1'b0, 32'h904);
        settle(); expect_grant("ar_m1", MID_M1, 32'h904, 1'b0, 32'hF1); tick();
        drive_m(MID_M1, 1'b1, 1'b1, 32'h700);
        bus.s_ack = 1'b0;
        settle(); check_eq("ar_lk0", bus.s_addr, 32'h700); tick();
        drive_m(MID_M0, 1'b1, 1'b1, 32'h800);
        settle(); check_eq("ar_lk1", bus.s_addr, 32'h700);
        #1;
        rst_n = 1'b0; bus.s_resp = 1'b1; bus.s_rdata = 32'h77;
        #1;
        check_eq("ar_errclr", 32'(err), 32'd0);
        check_eq("ar_resp",   32'({bus.m0_resp, bus.m1_resp}), 32'd0);
        check_eq("ar_unlock", bus.s_addr, 32'h800);
        sb.delete();
        tick();
        rst_n = 1'b1; bus.s_ack = 1'b1;
        settle(); expect_grant("ar_first", MID_M0, 32'h800, 1'b1, 32'h0); tick();
        bus.m0_req = 1'b0; bus.m1_req = 1'b0; bus.s_ack = 1'b0;
        bus.s_resp = 1'b1; bus.s_rdata = 32'h99;
        settle();
        check_eq("ar_rsp_drop", 32'({bus.m0_resp, bus.m1_resp}), 32'd0);
        check_eq("ar_err_pre",  32'(err), 32'd0);
        tick(); settle();
        check_eq("ar_err_set",  32'(err), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
